// File: rtl/uart_pkg.sv
// Shared definitions for the register-loading UART receiver: FSM encoding,
// frame geometry and the address/nibble split of a received byte.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = FRAME_BITS - 2;

    localparam int ADDR_MSB = 7;
    localparam int ADDR_LSB = 4;
    localparam int NIB_MSB  = 3;
    localparam int NIB_LSB  = 0;

    typedef struct packed {
        logic [ADDR_MSB-ADDR_LSB:0] addr;
        logic [NIB_MSB-NIB_LSB:0]   nib;
    } reg_cmd_t;

    function automatic reg_cmd_t decode_cmd(input logic [7:0] b);
        reg_cmd_t c;
        c.addr = b[ADDR_MSB:ADDR_LSB];
        c.nib  = b[NIB_MSB:NIB_LSB];
        return c;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 byte receiver: 2-flop synchronizer, start/data/stop FSM, LSB-first shifter.
// byte_valid / frame_err are single-cycle strobes in the stop-bit sample cycle.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int PW = $clog2(OVERSAMPLE);
    localparam logic [PW-1:0] START_PH = PW'(OVERSAMPLE / 2);
    localparam logic [PW-1:0] BIT_PH   = PW'(OVERSAMPLE - 1);

    rx_state_e     state;
    logic          rx_s1, rx_s2, rx_prev;
    logic [1:0]    sync_fill;
    logic [PW-1:0] phase;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          fall, bit_tick;

    // rx_prev only ever captures real samples (never the reset value of the
    // synchronizer), so a line held low through reset cannot fake an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1     <= 1'b1;
            rx_s2     <= 1'b1;
            rx_prev   <= 1'b0;
            sync_fill <= 2'b00;
        end else begin
            rx_s1     <= rx;
            rx_s2     <= rx_s1;
            sync_fill <= {sync_fill[0], 1'b1};
            rx_prev   <= rx_s2 & sync_fill[1];
        end
    end

    assign fall     = rx_prev & ~rx_s2;
    assign bit_tick = (phase == BIT_PH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            phase   <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    phase   <= '0;
                    bit_idx <= '0;
                    if (fall) state <= ST_START;
                end
                ST_START: begin
                    if (phase == START_PH) begin
                        phase <= '0;
                        state <= rx_s2 ? ST_IDLE : ST_DATA;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        phase   <= '0;
                        shreg   <= {rx_s2, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'(DATA_BITS - 1)) state <= ST_STOP;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (bit_tick) begin
                        phase <= '0;
                        state <= ST_IDLE;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign byte_valid = (state == ST_STOP) && bit_tick &&  rx_s2;
    assign frame_err  = (state == ST_STOP) && bit_tick && !rx_s2;
    assign busy       = (state != ST_IDLE);
    assign rx_byte    = shreg;

endmodule

// File: rtl/uart_reg_rx.sv
// Register file loaded over UART: an even-address byte stages a low nibble,
// the matching odd-address byte supplies the high nibble and commits the register.
module uart_reg_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 5,
    parameter int NUM_REGS   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx,
    output logic [8*NUM_REGS-1:0] regs,
    output logic [NUM_REGS-1:0]   wr_strobe,
    output logic                  frame_err,
    output logic                  busy
);

    logic [7:0] rx_byte;
    logic       byte_valid, core_ferr;

    uart_rx_core #(.OVERSAMPLE(OVERSAMPLE)) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (core_ferr),
        .busy       (busy)
    );

    reg_cmd_t                  cmd;
    logic [2:0]                k;
    logic                      k_ok;
    logic [NUM_REGS-1:0][7:0]  reg_q;
    logic [3:0]                hold;
    logic [2:0]                hold_idx;
    logic                      hold_valid;

    assign cmd  = decode_cmd(rx_byte);
    assign k    = cmd.addr[3:1];
    assign k_ok = (int'(k) < NUM_REGS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_q      <= '0;
            hold       <= '0;
            hold_idx   <= '0;
            hold_valid <= 1'b0;
            wr_strobe  <= '0;
            frame_err  <= 1'b0;
        end else begin
            wr_strobe <= '0;
            frame_err <= core_ferr;
            if (core_ferr) begin
                hold_valid <= 1'b0;
            end else if (byte_valid && k_ok) begin
                if (!cmd.addr[0]) begin
                    hold       <= cmd.nib;
                    hold_idx   <= k;
                    hold_valid <= 1'b1;
                end else begin
                    // Any odd byte in range consumes the staged nibble, match or not.
                    hold_valid <= 1'b0;
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (hold_valid && hold_idx == k && 3'(i) == k) begin
                            reg_q[i]     <= {cmd.nib, hold};
                            wr_strobe[i] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign regs = reg_q;

endmodule
